// File: rtl/axi4s_pkt_gen.sv
// AXI4-Stream packet generator: incrementing 32-bit words framed with tlast,
// optional inter-packet gap, run ends on packet count or on stop at a boundary.
module axi4s_pkt_gen #(
  parameter int unsigned LENW = 16,
  parameter int unsigned DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [LENW-1:0]   cfg_len,
  input  logic [LENW-1:0]   cfg_num,
  input  logic [LENW-1:0]   cfg_gap,
  input  logic [DW-1:0]     cfg_init,
  output logic              busy,
  output logic              done,
  output logic [LENW-1:0]   pkt_cnt,
  output logic [DW-1:0]     m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [DW/8-1:0]   m_tkeep
);

  localparam int unsigned KW = DW / 8;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t          r_state, w_state_nxt;
  logic [LENW-1:0] r_len, r_num, r_gap, r_beat, r_gap_cnt, r_pkt_cnt;
  logic [DW-1:0]   r_tdata;
  logic            r_stop, r_busy, r_done, r_tvalid, r_tlast;

  logic [LENW-1:0] w_len_nxt, w_num_nxt, w_gap_nxt, w_beat_nxt, w_gap_cnt_nxt, w_pkt_cnt_nxt;
  logic [DW-1:0]   w_tdata_nxt;
  logic            w_stop_nxt, w_busy_nxt, w_done_nxt, w_tvalid_nxt, w_tlast_nxt;

  logic            w_start_ok, w_xfer, w_last_xfer, w_stop_any, w_num_hit;
  logic            w_gap_exp, w_run_end, w_first_last;
  logic [LENW-1:0] w_cnt_inc, w_len_eff;

  // A start landing on the done cycle is ignored; the run still counts as ending.
  assign w_start_ok   = (r_state == S_IDLE) && start && !r_done;
  assign w_xfer       = r_tvalid && m_tready;
  assign w_last_xfer  = (r_state == S_SEND) && w_xfer && r_tlast;
  assign w_stop_any   = r_stop | stop;
  assign w_cnt_inc    = r_pkt_cnt + LENW'(1);
  assign w_num_hit    = (r_num != '0) && (w_cnt_inc == r_num);
  assign w_gap_exp    = (r_state == S_GAP) && (r_gap_cnt == '0);
  assign w_run_end    = (w_last_xfer && (w_num_hit || w_stop_any)) || (w_gap_exp && w_stop_any);
  assign w_len_eff    = (cfg_len == '0) ? LENW'(1) : cfg_len;
  assign w_first_last = (r_len == LENW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_last_xfer) begin
          if (w_run_end)        w_state_nxt = S_IDLE;
          else if (r_gap != '0) w_state_nxt = S_GAP;
          else                  w_state_nxt = S_SEND;
        end
      end
      S_GAP: if (w_gap_exp) w_state_nxt = w_run_end ? S_IDLE : S_SEND;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered datapath and outputs.
  always_comb begin
    w_len_nxt     = r_len;
    w_num_nxt     = r_num;
    w_gap_nxt     = r_gap;
    w_beat_nxt    = r_beat;
    w_gap_cnt_nxt = r_gap_cnt;
    w_pkt_cnt_nxt = r_pkt_cnt;
    w_tdata_nxt   = r_tdata;
    w_tvalid_nxt  = r_tvalid;
    w_tlast_nxt   = r_tlast;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_stop_nxt    = r_stop | (stop && (r_state != S_IDLE));
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_len_nxt     = w_len_eff;
          w_num_nxt     = cfg_num;
          w_gap_nxt     = cfg_gap;
          w_beat_nxt    = '0;
          w_pkt_cnt_nxt = '0;
          w_tdata_nxt   = cfg_init;
          w_tvalid_nxt  = 1'b1;
          w_tlast_nxt   = (w_len_eff == LENW'(1));
          w_busy_nxt    = 1'b1;
          w_stop_nxt    = 1'b0;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          w_tdata_nxt = r_tdata + DW'(1);
          if (r_tlast) begin
            w_pkt_cnt_nxt = w_cnt_inc;
            w_beat_nxt    = '0;
            if (w_run_end) begin
              w_tvalid_nxt = 1'b0;
              w_tlast_nxt  = 1'b0;
              w_busy_nxt   = 1'b0;
              w_done_nxt   = 1'b1;
              w_stop_nxt   = 1'b0;
            end else if (r_gap != '0) begin
              w_tvalid_nxt  = 1'b0;
              w_tlast_nxt   = 1'b0;
              w_gap_cnt_nxt = r_gap - LENW'(1);
            end else begin
              w_tlast_nxt = w_first_last;
            end
          end else begin
            w_beat_nxt  = r_beat + LENW'(1);
            w_tlast_nxt = ((r_beat + LENW'(1)) == (r_len - LENW'(1)));
          end
        end
      end
      S_GAP: begin
        if (w_gap_exp) begin
          if (w_run_end) begin
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
            w_stop_nxt = 1'b0;
          end else begin
            w_tvalid_nxt = 1'b1;
            w_tlast_nxt  = w_first_last;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - LENW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len     <= '0;
      r_num     <= '0;
      r_gap     <= '0;
      r_beat    <= '0;
      r_gap_cnt <= '0;
      r_pkt_cnt <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_stop    <= 1'b0;
    end else begin
      r_len     <= w_len_nxt;
      r_num     <= w_num_nxt;
      r_gap     <= w_gap_nxt;
      r_beat    <= w_beat_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_pkt_cnt <= w_pkt_cnt_nxt;
      r_tdata   <= w_tdata_nxt;
      r_tvalid  <= w_tvalid_nxt;
      r_tlast   <= w_tlast_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_stop    <= w_stop_nxt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign pkt_cnt  = r_pkt_cnt;
  assign m_tdata  = r_tdata;
  assign m_tvalid = r_tvalid;
  assign m_tlast  = r_tlast;
  assign m_tkeep  = {KW{r_tvalid}};

endmodule

// File: tb/tb_axi4s_pkt_gen.sv
// Bench for axi4s_pkt_gen: per-run reference model of beat sequence, framing,
// gaps and run end, driven with random tready stalls.
module tb_axi4s_pkt_gen;

  logic        clk = 1'b0;
  logic        rst, start, stop, m_tready;
  logic [15:0] cfg_len, cfg_num, cfg_gap;
  logic [31:0] cfg_init;
  logic        busy, done, m_tvalid, m_tlast;
  logic [15:0] pkt_cnt;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi4s_pkt_gen #(.LENW(16), .DW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_num(cfg_num), .cfg_gap(cfg_gap), .cfg_init(cfg_init),
    .busy(busy), .done(done), .pkt_cnt(pkt_cnt),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tkeep(m_tkeep)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One run: model predicts every beat, the gap lengths, pkt_cnt and the end cycle.
  // Returns positioned at the negedge on which done is expected high.
  task automatic run_case(input int len, input int num, input int gap, input logic [31:0] init,
                          input int stall_pct, input int hold_beat, input int stop_at,
                          input bit poke_start);
    int          eff_len, beat, pkts, beats, low_cnt, hold_left, cycles;
    logic [31:0] exp_d, prev_d;
    bit          prev_v, prev_r, prev_l, in_gap, stop_pend, end_exp, fin, poked;
    eff_len = (len == 0) ? 1 : len;
    @(negedge clk);
    check_eq("done_pulse_width", 64'(done), 0);
    cfg_len = 16'(len); cfg_num = 16'(num); cfg_gap = 16'(gap); cfg_init = init;
    start = 1'b1; m_tready = 1'b0; stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cfg_len = 16'($urandom); cfg_num = 16'($urandom); cfg_gap = 16'($urandom); cfg_init = $urandom;
    check_eq("busy_after_start", 64'(busy), 1);
    exp_d = init; beat = 0; pkts = 0; beats = 0; low_cnt = 0; hold_left = 5; cycles = 0;
    prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0;
    in_gap = 0; stop_pend = 0; end_exp = 0; fin = 0; poked = 0;
    while (!fin) begin
      if (end_exp) begin
        check_eq("done_at_end", 64'(done), 1);
        check_eq("busy_at_end", 64'(busy), 0);
        check_eq("tvalid_at_end", 64'(m_tvalid), 0);
        check_eq("pkt_cnt_final", 64'(pkt_cnt), 64'(pkts));
        fin = 1;
      end else begin
        check_eq("done_early", 64'(done), 0);
        check_eq("busy_run", 64'(busy), 1);
        check_eq("pkt_cnt", 64'(pkt_cnt), 64'(pkts));
        if (prev_v && !prev_r) begin
          check_eq("hold_tvalid", 64'(m_tvalid), 1);
          check_eq("hold_tdata", 64'(m_tdata), 64'(prev_d));
          check_eq("hold_tlast", 64'(m_tlast), 64'(prev_l));
        end
        if (m_tvalid) begin
          if (in_gap) begin
            check_eq("gap_len", 64'(low_cnt), 64'(gap));
            in_gap = 0;
          end
          check_eq("tdata", 64'(m_tdata), 64'(exp_d));
          check_eq("tlast", 64'(m_tlast), 64'(beat == eff_len - 1));
          check_eq("tkeep", 64'(m_tkeep), 64'hF);
        end else if (in_gap) begin
          low_cnt++;
        end else begin
          check_eq("tvalid_drop", 64'(m_tvalid), 1);
        end
        if (hold_beat >= 0 && beat == hold_beat && m_tvalid && hold_left > 0) begin
          m_tready = 1'b0;
          hold_left--;
        end else begin
          m_tready = ($urandom_range(0, 99) >= stall_pct);
        end
        stop = (stop_at >= 0) && (beats == stop_at) && !stop_pend;
        if (stop) stop_pend = 1;
        start = poke_start && !poked && (beats == 1);
        if (start) poked = 1;
        if (m_tvalid && m_tready) begin
          exp_d++;
          beats++;
          if (beat == eff_len - 1) begin
            pkts++;
            beat = 0;
            if ((num != 0 && pkts == num) || stop_pend) end_exp = 1;
            else if (gap > 0) begin in_gap = 1; low_cnt = 0; end
          end else begin
            beat++;
          end
        end else if (in_gap && low_cnt == gap && stop_pend) begin
          end_exp = 1;
        end
        prev_v = m_tvalid; prev_r = m_tready; prev_d = m_tdata; prev_l = m_tlast;
      end
      if (!fin) begin
        cycles++;
        if (cycles > 20000) begin
          check_eq("run_timeout", 0, 1);
          fin = 1;
        end
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; m_tready = 1'b0;
    cfg_len = '0; cfg_num = '0; cfg_gap = '0; cfg_init = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_done", 64'(done), 0);
    check_eq("rst_tvalid", 64'(m_tvalid), 0);
    check_eq("rst_tdata", 64'(m_tdata), 0);
    check_eq("rst_pkt_cnt", 64'(pkt_cnt), 0);
    rst = 1'b0;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_eq("idle_stop_ignored", 64'(busy), 0);

    run_case(4, 2, 0, 32'h10, 0, -1, -1, 0);
    run_case(3, 1, 0, $urandom, 0, 2, -1, 0);
    run_case(2, 3, 4, $urandom, 0, -1, -1, 0);
    run_case(5, 0, 0, $urandom, 0, -1, 12, 0);
    run_case(0, 2, 0, 32'hFFFF_FFFF, 0, -1, -1, 0);

    // Start on the done cycle must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("done_cycle_start_busy", 64'(busy), 0);
    check_eq("done_cycle_start_tvalid", 64'(m_tvalid), 0);

    // Async reset mid-packet, then a fresh run with an ignored start while busy.
    cfg_len = 16'd8; cfg_num = 16'd0; cfg_gap = 16'd0; cfg_init = 32'hABCD_0000;
    m_tready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("arst_tvalid", 64'(m_tvalid), 0);
    check_eq("arst_busy", 64'(busy), 0);
    check_eq("arst_tdata", 64'(m_tdata), 0);
    check_eq("arst_tlast", 64'(m_tlast), 0);
    check_eq("arst_pkt_cnt", 64'(pkt_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    run_case(3, 2, 1, $urandom, 20, -1, -1, 1);

    for (int i = 0; i < 4; i++)
      run_case($urandom_range(0, 6), $urandom_range(1, 4), $urandom_range(0, 3), $urandom,
               25, -1, -1, 0);

    run_case($urandom_range(1, 7), 0, $urandom_range(0, 2), $urandom, 30, -1, 1000, 0);

    @(negedge clk);
    check_eq("final_done_low", 64'(done), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
